// File: rtl/cb_packer_if.sv
// Code-block stream in, framed byte stream and block status out.
interface cb_packer_if;
    logic        cb_data;
    logic        start;
    logic        stop;
    logic        filling;
    logic        crc;
    logic        cb_size;
    logic        err_clr;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_valid;
    logic        out_ready;
    logic        blk_done;
    logic [12:0] blk_len;
    logic [6:0]  blk_fill;
    logic        len_err;
    logic        crc_err;
    logic        proto_err;
    logic        ovf_err;

    modport master (
        output cb_data, start, stop, filling, crc, cb_size, err_clr, out_ready,
        input  out_data, out_sop, out_eop, out_valid,
        input  blk_done, blk_len, blk_fill, len_err, crc_err, proto_err, ovf_err
    );

    modport slave (
        input  cb_data, start, stop, filling, crc, cb_size, err_clr, out_ready,
        output out_data, out_sop, out_eop, out_valid,
        output blk_done, blk_len, blk_fill, len_err, crc_err, proto_err, ovf_err
    );
endinterface

// File: rtl/cb_packer.sv
// Packs a serial code-block stream MSB-first into bytes, buffers them with
// sop/eop framing in a show-ahead FIFO and reports per-block length/CRC status.
module cb_packer #(
    parameter int unsigned K_PLUS     = 6144,
    parameter int unsigned K_MINUS    = 6080,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    cb_packer_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = 13;
    localparam int unsigned FW = 7;

    typedef enum logic {IDLE, IN_BLK} state_t;
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    idx_q, idx_d;
    logic          sop_pend_q, sop_pend_d;
    logic          size_q, size_d;
    logic [LW-1:0] len_q, len_d, crc_q, crc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          seen_q, seen_d, order_q, order_d;
    logic          done_q, done_d;
    logic [LW-1:0] blk_len_q, blk_len_d;
    logic [FW-1:0] blk_fill_q, blk_fill_d;
    logic          len_err_q, len_err_d, crc_err_q, crc_err_d;
    logic          proto_q, proto_d, ovf_q, ovf_d;
    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          valid_q, valid_d;

    logic          accept, first, proto_set, wr_req, sop_now;
    entry_t        wr_entry, head;
    logic [7:0]    base_byte, cur_byte;
    logic [2:0]    base_idx;
    logic [LW-1:0] len_nx, crc_nx;
    logic [FW-1:0] fill_nx;
    logic          seen_nx, order_nx, size_nx;
    logic          rd_en, full, wr_ok, ovf_set;

    // Block framing FSM plus bit packing, counters and end-of-block status.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        idx_d      = idx_q;
        sop_pend_d = sop_pend_q;
        size_d     = size_q;
        len_d      = len_q;
        crc_d      = crc_q;
        fill_d     = fill_q;
        seen_d     = seen_q;
        order_d    = order_q;
        done_d     = 1'b0;
        blk_len_d  = blk_len_q;
        blk_fill_d = blk_fill_q;
        len_err_d  = len_err_q;
        crc_err_d  = crc_err_q;
        accept     = 1'b0;
        first      = 1'b0;
        proto_set  = 1'b0;
        wr_req     = 1'b0;
        wr_entry   = '0;
        sop_now    = 1'b0;
        base_byte  = '0;
        base_idx   = '0;
        cur_byte   = '0;
        len_nx     = '0;
        crc_nx     = '0;
        fill_nx    = '0;
        seen_nx    = 1'b0;
        order_nx   = 1'b0;
        size_nx    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    first  = 1'b1;
                    if (!bus.stop) state_d = IN_BLK;
                end else if (bus.stop) begin
                    proto_set = 1'b1;
                end
            end
            IN_BLK: begin
                accept = 1'b1;
                if (bus.start) proto_set = 1'b1;
                if (bus.stop)  state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            base_byte = first ? 8'h00 : byte_q;
            base_idx  = first ? 3'd0 : idx_q;
            sop_now   = first | sop_pend_q;
            cur_byte  = base_byte;
            cur_byte[3'd7 - base_idx] = bus.cb_data;
            len_nx   = first ? LW'(1) : ((&len_q) ? len_q : len_q + LW'(1));
            fill_nx  = first ? FW'(bus.filling)
                             : ((&fill_q) ? fill_q : fill_q + FW'(bus.filling));
            crc_nx   = first ? LW'(bus.crc)
                             : ((&crc_q) ? crc_q : crc_q + LW'(bus.crc));
            order_nx = first ? 1'b0 : (order_q | (seen_q & ~bus.crc));
            seen_nx  = (first ? 1'b0 : seen_q) | bus.crc;
            size_nx  = first ? bus.cb_size : size_q;

            len_d   = len_nx;
            crc_d   = crc_nx;
            fill_d  = fill_nx;
            order_d = order_nx;
            seen_d  = seen_nx;
            size_d  = size_nx;

            // Emit on a full byte or on the last bit (left-aligned, zero padded).
            if (base_idx == 3'd7 || bus.stop) begin
                wr_req     = 1'b1;
                wr_entry   = '{sop: sop_now, eop: bus.stop, data: cur_byte};
                byte_d     = 8'h00;
                idx_d      = 3'd0;
                sop_pend_d = 1'b0;
            end else begin
                byte_d     = cur_byte;
                idx_d      = base_idx + 3'd1;
                sop_pend_d = sop_now;
            end

            if (bus.stop) begin
                done_d     = 1'b1;
                blk_len_d  = len_nx;
                blk_fill_d = fill_nx;
                len_err_d  = len_nx != (size_nx ? LW'(K_PLUS) : LW'(K_MINUS));
                crc_err_d  = (crc_nx != LW'(0) && crc_nx != LW'(24)) || order_nx;
            end
        end
    end

    // FIFO bookkeeping and sticky error flags (set wins over clear).
    always_comb begin
        rd_en    = valid_q && bus.out_ready;
        full     = cnt_q == (AW+1)'(FIFO_DEPTH);
        wr_ok    = wr_req && (!full || rd_en);
        ovf_set  = wr_req && full && !rd_en;
        cnt_d    = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_en);
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        valid_d  = cnt_d != '0;
        proto_d  = (proto_q & ~bus.err_clr) | proto_set;
        ovf_d    = (ovf_q & ~bus.err_clr) | ovf_set;
    end

    // State, counter, status and FIFO pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            idx_q      <= '0;
            sop_pend_q <= 1'b0;
            size_q     <= 1'b0;
            len_q      <= '0;
            crc_q      <= '0;
            fill_q     <= '0;
            seen_q     <= 1'b0;
            order_q    <= 1'b0;
            done_q     <= 1'b0;
            blk_len_q  <= '0;
            blk_fill_q <= '0;
            len_err_q  <= 1'b0;
            crc_err_q  <= 1'b0;
            proto_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            idx_q      <= idx_d;
            sop_pend_q <= sop_pend_d;
            size_q     <= size_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            fill_q     <= fill_d;
            seen_q     <= seen_d;
            order_q    <= order_d;
            done_q     <= done_d;
            blk_len_q  <= blk_len_d;
            blk_fill_q <= blk_fill_d;
            len_err_q  <= len_err_d;
            crc_err_q  <= crc_err_d;
            proto_q    <= proto_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_data  = head.data;
    assign bus.out_sop   = head.sop;
    assign bus.out_eop   = head.eop;
    assign bus.out_valid = valid_q;
    assign bus.blk_done  = done_q;
    assign bus.blk_len   = blk_len_q;
    assign bus.blk_fill  = blk_fill_q;
    assign bus.len_err   = len_err_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.proto_err = proto_q;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: doc/cb_packer.md
# cb_packer

Code-block byte packer sitting directly downstream of the code-block segmentation stage. It samples the serial code-block stream (`cb_data` with `start`/`stop`/`filling`/`crc` qualifiers and `cb_size`) and packs bits MSB-first into bytes. It buffers the bytes in an internal FIFO with sop/eop framing for the turbo-encoder input interface. It checks each block's length, filler and CRC framing, and reports per-block status.

## Interface
Parameters:
- `K_PLUS`, 6144: expected block length in bits when `cb_size`=1.
- `K_MINUS`, 6080: expected block length in bits when `cb_size`=0.
- `FIFO_DEPTH`, 16: byte-FIFO entries (power of 2, ≥4).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cb_data` in 1: serial bit.
- `start` in 1: first bit of block this cycle.
- `stop` in 1: last bit of block this cycle.
- `filling` in 1: current bit is a filler bit.
- `crc` in 1: current bit is a CB-CRC bit.
- `cb_size` in 1: size select, sampled on `start` cycle.
- `err_clr` in 1: clears sticky error flags.
- `out_data` out 8: packed byte, first received bit in bit 7.
- `out_sop` out 1: byte is first of block.
- `out_eop` out 1: byte is last of block.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head when `out_valid`&&`out_ready`.
- `blk_done` out 1: one-cycle status pulse.
- `blk_len` out 13: bits received in finished block.
- `blk_fill` out 7: filler bits in finished block (saturates at 127).
- `len_err` out 1: `blk_len` ≠ expected K; valid with `blk_done`.
- `crc_err` out 1: CRC framing error; valid with `blk_done`.
- `proto_err` out 1: sticky; stray `start`/`stop`.
- `ovf_err` out 1: sticky; byte dropped because the FIFO was full.

## Operation
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0, sticky flags 0.
- States:
  - IDLE → IN_BLK when `start`=1. The bit is accepted as bit 0, `cb_size` is latched, and the counters are reset to this bit.
  - IN_BLK: a bit is accepted every cycle.
  - IN_BLK → IDLE on `stop`. The `stop` bit is accepted.
  - `start`&&`stop` in IDLE is a 1-bit block: sop=eop=1, `len_err`=1.
- Stray control:
  - `start` in IN_BLK is treated as an ordinary data bit and sets `proto_err`.
  - `stop` in IDLE is ignored and sets `proto_err`.
  - In IDLE, all other inputs are ignored.
- Packing:
  - Shift register plus 3-bit bit index.
  - On the 8th bit, or on the `stop` bit, the byte {shreg, bit} is written to the FIFO. A partial byte is left-aligned with zero LSB padding.
  - `sop` is set on the first byte written after `start`; `eop` is set on the byte carrying the `stop` bit.
  - At most one write per cycle.
- Counters:
  - `len_cnt` is 13 bits and saturates at 8191.
  - `fill_cnt` counts bits with `filling`=1.
  - `crc_cnt` counts bits with `crc`=1.
- CRC framing rule: `crc_err`=1 if `crc_cnt` ∉ {0,24}, or if any non-CRC bit follows a CRC bit within the block.
- `len_err`: `blk_len` ≠ (latched `cb_size` ? `K_PLUS` : `K_MINUS`).
- FIFO:
  - Synchronous, show-ahead; each entry is {sop, eop, byte}.
  - Write when full: the entry is dropped and `ovf_err` is set. There is no upstream backpressure.
  - Simultaneous read and write when full: the read frees a slot, the write succeeds, and there is no overflow.
  - Simultaneous read and write when empty: only the write occurs.
- `err_clr` clears `proto_err` and `ovf_err`. If a set condition occurs in the same cycle, set wins.
- Reset asserted mid-block: everything is cleared immediately, including FIFO contents and the partial byte. No `blk_done` is issued.

## Timing
- Bit sampled at edge n. If it completes a byte, the FIFO write occurs at edge n and `out_valid`=1 from edge n onward (1-cycle latency, registered).
- `out_data`/`out_sop`/`out_eop` are stable while `out_valid`&&!`out_ready`.
- `blk_done` is high for exactly the one cycle after the edge that samples `stop`. `blk_len`, `blk_fill`, `len_err` and `crc_err` are valid in that same cycle and hold until the next `blk_done`.
- Sticky flags assert the cycle after the offending edge.
- Back-to-back blocks: `start` may arrive the cycle after `stop` with no bubble.

## Test plan
- Block with `cb_size`=1: 6144 bits (data pattern 0xA5 repeated, first 8 bits `filling`=1, last 24 bits `crc`=1), `out_ready`=1 → 768 bytes, first byte 0xA5 with sop, last byte with eop. `blk_done`: `blk_len`=6144, `blk_fill`=8, `len_err`=0, `crc_err`=0.
- Block with `cb_size`=0 and 6083 bits of all-ones → last byte 0xE0 with eop. `blk_len`=6083, `len_err`=1.
- `out_ready`=0 for 20 bytes, `FIFO_DEPTH`=16 → 16 bytes retained in order, `ovf_err`=1. `err_clr` then clears it.
- CRC flag on 23 bits, then a non-CRC bit → `crc_err`=1. Stray `stop` in IDLE → `proto_err`=1, no FIFO write.
- `start`&&`stop` same cycle with bit 1 → byte 0x80 with sop=eop=1, `blk_len`=1, `len_err`=1. A back-to-back `start` on the next cycle is accepted.
- `reset` asserted after 100 bits of a block → `out_valid`=0 and no `blk_done`. A next full block packs correctly.
